// File: rtl/vehicle_sensor_conditioner.sv
// vehicle_sensor_conditioner
//   Synchronizes and debounces the side-road loop sensor, counts queued
//   vehicles on each debounced arrival, retires one vehicle per PASS_CYCLES
//   consecutive green cycles, and raises C while any vehicle is queued.
// Ports:
//   clk            - single clock, rising edge
//   reset          - synchronous, active-high
//   sensorRaw      - asynchronous loop-sensor level (1 = vehicle present)
//   nitkRoadLights - controller NITK road light (2'b00 = GREEN)
//   C              - car request, (queueCount != 0)
//   queueCount     - vehicles waiting
//   overflow       - sticky, an arrival was dropped at saturation
module vehicle_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PASS_CYCLES     = 3,
  parameter int COUNT_WIDTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sensorRaw,
  input  logic [1:0]             nitkRoadLights,
  output logic                   C,
  output logic [COUNT_WIDTH-1:0] queueCount,
  output logic                   overflow
);

  typedef enum logic [1:0] {STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW} db_state_t;

  localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] PASS_LAST = 8'(PASS_CYCLES);

  logic      s1, s2;
  db_state_t state;
  logic [7:0] match_cnt, pass_cnt;
  logic      arrive, depart, green, q_empty, q_full;

  assign green   = (nitkRoadLights == 2'b00);
  assign q_empty = (queueCount == '0);
  assign q_full  = (queueCount == '1);
  assign C       = !q_empty;

  // arrive/depart are decoded from current state so the queue moves on the
  // same edge that completes the debounce or the green run.
  always_comb begin
    arrive = 1'b0;
    unique case (state)
      STABLE_LOW: arrive = s2 && (DB_LAST == 8'd1);
      CHECK_HIGH: arrive = s2 && ((match_cnt + 8'd1) == DB_LAST);
      default:    arrive = 1'b0;
    endcase
  end

  assign depart = green && !q_empty && ((pass_cnt + 8'd1) == PASS_LAST);

  // synchronizer + debounce FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      state     <= STABLE_LOW;
      match_cnt <= 8'd0;
    end else begin
      s1 <= sensorRaw;
      s2 <= s1;
      unique case (state)
        STABLE_LOW: if (s2) begin
          if (DB_LAST == 8'd1) begin state <= STABLE_HIGH; match_cnt <= 8'd0; end
          else                 begin state <= CHECK_HIGH;  match_cnt <= 8'd1; end
        end
        CHECK_HIGH:
          if (!s2)         begin state <= STABLE_LOW;  match_cnt <= 8'd0; end
          else if (arrive) begin state <= STABLE_HIGH; match_cnt <= 8'd0; end
          else             match_cnt <= match_cnt + 8'd1;
        STABLE_HIGH: if (!s2) begin
          if (DB_LAST == 8'd1) begin state <= STABLE_LOW; match_cnt <= 8'd0; end
          else                 begin state <= CHECK_LOW;  match_cnt <= 8'd1; end
        end
        CHECK_LOW:
          if (s2) begin state <= STABLE_HIGH; match_cnt <= 8'd0; end
          else if ((match_cnt + 8'd1) == DB_LAST) begin
            state <= STABLE_LOW; match_cnt <= 8'd0;
          end else match_cnt <= match_cnt + 8'd1;
        default: begin state <= STABLE_LOW; match_cnt <= 8'd0; end
      endcase
    end
  end

  // green-run counter; any break in the run (or empty queue) restarts it
  always_ff @(posedge clk) begin
    if (reset || !green || q_empty || depart) pass_cnt <= 8'd0;
    else                                      pass_cnt <= pass_cnt + 8'd1;
  end

  // queue; simultaneous arrive+depart cancel, even at saturation
  always_ff @(posedge clk) begin
    if (reset) begin
      queueCount <= '0;
      overflow   <= 1'b0;
    end else begin
      unique case ({arrive, depart})
        2'b10: if (q_full) overflow <= 1'b1;
               else        queueCount <= queueCount + 1'b1;
        2'b01: queueCount <= queueCount - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/vehicle_sensor_conditioner.md
# vehicle_sensor_conditioner

Conditions the raw side-road (NITK road) vehicle loop-sensor signal and produces the car-present request `C` consumed by the traffic light controller top. It synchronizes and debounces the asynchronous sensor and counts queued vehicles on each debounced arrival. It also retires queued vehicles while the NITK road light is green, and holds `C` high as long as any vehicle remains queued. It sits directly upstream of the controller and observes the controller's `nitkRoadLights` output to track departures.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive identical synchronized samples required to accept a sensor level change; legal range 1..255.
- `PASS_CYCLES`, 3: consecutive green cycles per departing vehicle; legal range 1..255.
- `COUNT_WIDTH`, 4: width of the vehicle queue counter.
- `clk` input 1: single clock; all state on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `sensorRaw` input 1: asynchronous loop-sensor level; 1 means a vehicle is present.
- `nitkRoadLights` input 2: controller NITK road light; 2'b00 GREEN, 2'b01 YELLOW, 2'b10 RED, 2'b11 treated as not green.
- `C` output 1: car request to the controller; equals (queueCount != 0).
- `queueCount` output COUNT_WIDTH: vehicles waiting.
- `overflow` output 1: sticky; set when an arrival is dropped at saturation.

## Operation
- **Synchronizer:** two flops, sensorRaw → s1 → s2. Only s2 is used downstream.
- **Debounce FSM:** states STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW. An 8-bit match counter runs alongside it.
  - STABLE_LOW: when s2=1, go to CHECK_HIGH with the counter set to 1.
  - CHECK_HIGH: when s2=1, increment the counter. When the counter reaches DEBOUNCE_CYCLES, go to STABLE_HIGH and emit a one-cycle `arrive`. When s2=0, return to STABLE_LOW and clear the counter.
  - STABLE_HIGH and CHECK_LOW: symmetric to the above. No pulse is emitted on the return to STABLE_LOW.
  - DEBOUNCE_CYCLES=1: the transition to STABLE_HIGH happens on the first s2=1 sample.
- **Departure logic:** a pass counter increments each cycle nitkRoadLights==GREEN and queueCount!=0.
  - When it reaches PASS_CYCLES, emit a one-cycle `depart` and clear the counter.
  - Clear the counter whenever the light is not GREEN or the queue is empty.
  - A partial green run never carries over.
- **Queue update (per cycle):**
  - arrive only: +1. At all-ones, the count holds and `overflow` is set.
  - depart only: −1. `depart` cannot occur at 0.
  - arrive and depart together: unchanged, even at saturation; `overflow` is not set.
- `C` is a combinational decode of the queueCount register; it adds no latency.
- **Reset:**
  - Takes effect at the next edge regardless of FSM state or counts.
  - Clears s1, s2, the FSM (to STABLE_LOW), both counters, queueCount, and `overflow`.
  - A sensor still high after reset release is counted as a new arrival after the normal debounce.

## Timing
- Reset values: C=0, queueCount=0, overflow=0.
- Arrival latency: sensorRaw is first sampled high at edge n and stays high.
  - s2=1 after edge n+1.
  - queueCount increments and C rises after edge n+1+DEBOUNCE_CYCLES, i.e. edge n+5 at the default.
- Glitch rejection: any high pulse captured for fewer than DEBOUNCE_CYCLES s2 samples produces no arrival.
- One arrival per debounced rising edge: a sensor held high indefinitely counts once.
- Departure latency: the light is GREEN from edge g with queueCount≥1.
  - First decrement after edge g+PASS_CYCLES−1, counting the sample at g as cycle 1.
  - Subsequent decrements every PASS_CYCLES cycles while GREEN persists.
- C falls in the same cycle queueCount becomes 0.

## Test plan
- **Reset hold:** reset=1 for 4 cycles with sensorRaw toggling → C=0, queueCount=0, overflow=0 throughout. After release with sensorRaw=0 → outputs stay 0.
- **Single arrival:** sensorRaw high from edge 10 for 20 cycles (defaults) → queueCount becomes 1 and C rises after edge 15. No further increments. Release → count unchanged.
- **Glitches:** pulses of 1, 2 and 3 cycles separated by 10-cycle gaps → queueCount stays 0. A subsequent 6-cycle pulse → queueCount=1.
- **Queue drain:** 3 debounced arrivals, then nitkRoadLights=GREEN for 9 cycles → decrements at green cycles 3, 6 and 9; C falls with the third. A GREEN→RED switch after 2 green cycles → no decrement and the pass counter clears.
- **Saturation:** 16 arrivals with COUNT_WIDTH=4 → queueCount=15 and overflow=1 held. An arrival coinciding with a depart → count unchanged.
- **Reset mid-operation:** queueCount=5, FSM in CHECK_HIGH → reset for 1 cycle clears all state. sensorRaw still high → recounted to 1 after the debounce.
